// File: rtl/pll_md_ctrl.sv
// PLL MD-port sequencer: serializes register read/write commands onto the MD bus
// and runs the PLL reset / lock-wait handshake with a lock timeout.
module pll_md_ctrl #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo,
  output logic       pll_rst,
  input  logic       pll_lock,
  output logic       locked
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WR, S_RD, S_RD_WAIT, S_RST, S_LOCK_WAIT, S_RESP
  } state_e;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_APL = 2'b10;

  localparam logic [1:0] MD_NOP   = 2'b00;
  localparam logic [1:0] MD_WRITE = 2'b01;
  localparam logic [1:0] MD_READ  = 2'b10;
  localparam logic [1:0] MD_ADDR  = 2'b11;

  localparam logic [15:0] RD_LOAD  = 16'(RD_LAT - 1);
  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_VAL   = 16'(LOCK_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic        lock_s;

  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  md_opc_q, md_opc_d;
  logic [7:0]  md_wdi_q, md_wdi_d;
  logic        pll_rst_q, pll_rst_d;

  assign lock_s = sync_q[1];

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          case (cmd_op)
            OP_WR, OP_RD: state_d = S_ADDR;
            OP_APL: begin
              state_d = S_RST;
              cnt_d   = RST_LOAD;
            end
            default: begin
              state_d   = S_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: state_d = (op_q == OP_WR) ? S_WR : S_RD;
      S_WR: begin
        state_d   = S_RESP;
        rsp_err_d = 1'b0;
      end
      S_RD: begin
        state_d = S_RD_WAIT;
        cnt_d   = RD_LOAD;
      end
      S_RD_WAIT: begin
        if (cnt_q == 16'd0) begin
          rsp_rdata_d = md_rdo;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RST: begin
        if (cnt_q == 16'd0) begin
          state_d = S_LOCK_WAIT;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_LOCK_WAIT: begin
        // Lock takes priority over timeout on the final cycle
        if (lock_s) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b0;
        end else if (cnt_q == TO_VAL) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it
  always_comb begin
    md_opc_d    = MD_NOP;
    md_wdi_d    = 8'h00;
    pll_rst_d   = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_d)
      S_ADDR: begin
        md_opc_d = MD_ADDR;
        md_wdi_d = addr_d;
      end
      S_WR: begin
        md_opc_d = MD_WRITE;
        md_wdi_d = wdata_d;
      end
      S_RD:    md_opc_d    = MD_READ;
      S_RST:   pll_rst_d   = 1'b1;
      S_RESP:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      cnt_q       <= 16'd0;
      sync_q      <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      md_opc_q    <= MD_NOP;
      md_wdi_q    <= 8'h00;
      pll_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], pll_lock};
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      md_opc_q    <= md_opc_d;
      md_wdi_q    <= md_wdi_d;
      pll_rst_q   <= pll_rst_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign locked    = lock_s && (state_q != S_RST) && (state_q != S_LOCK_WAIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign md_opc    = md_opc_q;
  assign md_ainc   = 1'b0;
  assign md_wdi    = md_wdi_q;
  assign pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_md_ctrl.sv
// Directed bench for pll_md_ctrl: MD write/read sequencing, apply/lock/timeout, reset abort.
module tb_pll_md_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [1:0] md_opc;
  logic       md_ainc;
  logic [7:0] md_wdi, md_rdo;
  logic       pll_rst, pll_lock, locked;

  int total = 0;
  int bad   = 0;

  pll_md_ctrl #(.RD_LAT(2), .RST_CYCLES(16), .LOCK_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .md_opc(md_opc), .md_ainc(md_ainc), .md_wdi(md_wdi), .md_rdo(md_rdo),
    .pll_rst(pll_rst), .pll_lock(pll_lock), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    md_rdo = 8'h00; pll_lock = 1'b1;
    step(); step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rsp_rdata, rsp_err} !== 9'h000) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=00/0", rsp_rdata, rsp_err); end
    total++; if ({md_opc, md_ainc, md_wdi} !== 11'h000) begin bad++; $display("FAIL reset_md got=%b/%b/%h exp=00/0/00", md_opc, md_ainc, md_wdi); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL reset_pll_rst got=%b exp=0", pll_rst); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst_n = 1'b1;
    pll_lock = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_write();
    issue(2'b00, 8'h12, 8'hA5);
    step(); cmd_valid = 1'b0;  // cycle 1
    total++; if ({md_opc, md_wdi} !== {2'b11, 8'h12}) begin bad++; $display("FAIL wr_addr got=%b/%h exp=11/12", md_opc, md_wdi); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", cmd_ready); end
    step();  // cycle 2
    total++; if ({md_opc, md_wdi} !== {2'b01, 8'hA5}) begin bad++; $display("FAIL wr_data got=%b/%h exp=01/a5", md_opc, md_wdi); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%b exp=0", rsp_valid); end
    step();  // cycle 3
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL wr_rsp got=%b/%b exp=1/0", rsp_valid, rsp_err); end
    total++; if ({md_opc, md_wdi} !== 10'h000) begin bad++; $display("FAIL wr_md_idle got=%b/%h exp=00/00", md_opc, md_wdi); end
    step();
  endtask

  task automatic test_read();
    md_rdo = 8'hFF;
    issue(2'b01, 8'h07, 8'hEE);
    step(); cmd_valid = 1'b0;  // cycle 1
    total++; if ({md_opc, md_wdi} !== {2'b11, 8'h07}) begin bad++; $display("FAIL rd_addr got=%b/%h exp=11/07", md_opc, md_wdi); end
    step();  // cycle 2
    total++; if ({md_opc, md_wdi} !== {2'b10, 8'h00}) begin bad++; $display("FAIL rd_op got=%b/%h exp=10/00", md_opc, md_wdi); end
    step();  // cycle 3
    total++; if ({md_opc, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rd_wait got=%b/%b exp=00/0", md_opc, rsp_valid); end
    step(); md_rdo = 8'h3C;  // cycle 4: sample cycle
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_rsp got=%b exp=0", rsp_valid); end
    step(); md_rdo = 8'hFF;  // cycle 5
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h3C}) begin bad++; $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/3c", rsp_valid, rsp_err, rsp_rdata); end
    step();
    total++; if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h3C}) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/3c", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_apply_lock();
    int c, rst_hi, stray, lk_bad, got;
    rst_hi = 0; stray = 0; lk_bad = 0; got = -1;
    pll_lock = 1'b0;
    issue(2'b10, 8'h00, 8'h00);
    step(); cmd_valid = 1'b0;
    c = 1;
    while (c < 200 && got < 0) begin
      if (c == 27) pll_lock = 1'b1;  // 10 cycles after release at cycle 17
      if (rsp_valid) got = c;
      else begin
        if (pll_rst && c <= 16) rst_hi++;
        if ((pll_rst && c > 16) || (!pll_rst && c <= 16)) stray++;
        if (locked) lk_bad++;
        step(); c++;
      end
    end
    total++; if (rst_hi !== 16) begin bad++; $display("FAIL apl_rst_len got=%0d exp=16", rst_hi); end
    total++; if (stray !== 0) begin bad++; $display("FAIL apl_rst_shape got=%0d exp=0", stray); end
    total++; if (lk_bad !== 0) begin bad++; $display("FAIL apl_locked_early got=%0d exp=0", lk_bad); end
    total++; if (got !== 30) begin bad++; $display("FAIL apl_rsp_cycle got=%0d exp=30", got); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL apl_err got=%b exp=0", rsp_err); end
    step();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL apl_locked got=%b exp=1", locked); end
  endtask

  task automatic test_lock_loss();
    step();
    pll_lock = 1'b0;
    step();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_t1 got=%b exp=1", locked); end
    step();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_t2 got=%b exp=0", locked); end
    repeat (3) step();
    total++; if ({pll_rst, cmd_ready} !== 2'b01) begin bad++; $display("FAIL loss_no_reapply got=%b/%b exp=0/1", pll_rst, cmd_ready); end
  endtask

  task automatic test_timeout();
    int c, got;
    got = -1;
    issue(2'b10, 8'h00, 8'h00);
    step(); cmd_valid = 1'b0;
    c = 1;
    while (c < 400 && got < 0) begin
      if (rsp_valid) got = c;
      else begin step(); c++; end
    end
    // 16 reset cycles, then LOCK_WAIT cycles 17..117
    total++; if (got !== 118) begin bad++; $display("FAIL to_rsp_cycle got=%0d exp=118", got); end
    total++; if ({rsp_err, locked} !== 2'b10) begin bad++; $display("FAIL to_err got=%b/%b exp=1/0", rsp_err, locked); end
    step();
  endtask

  task automatic test_reserved();
    issue(2'b11, 8'h55, 8'h66);
    step(); cmd_valid = 1'b0;
    total++; if ({rsp_valid, rsp_err} !== 2'b11) begin bad++; $display("FAIL res_rsp got=%b/%b exp=1/1", rsp_valid, rsp_err); end
    total++; if ({md_opc, md_wdi, pll_rst} !== 11'h000) begin bad++; $display("FAIL res_quiet got=%b/%h/%b exp=00/00/0", md_opc, md_wdi, pll_rst); end
    step();
    total++; if ({cmd_ready, rsp_valid, md_opc} !== 4'b1000) begin bad++; $display("FAIL res_idle got=%b/%b/%b exp=1/0/00", cmd_ready, rsp_valid, md_opc); end
  endtask

  task automatic test_reset_abort();
    int rv;
    rv = 0;
    issue(2'b10, 8'h00, 8'h00);
    step(); cmd_valid = 1'b0;
    repeat (4) step();
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b exp=1", pll_rst); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({pll_rst, cmd_ready, rsp_valid} !== 3'b010) begin bad++; $display("FAIL abort_now got=%b/%b/%b exp=0/1/0", pll_rst, cmd_ready, rsp_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid || pll_rst) rv++;
    end
    total++; if (rv !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", rv); end
  endtask

  task automatic test_back_to_back();
    md_rdo = 8'h99;
    issue(2'b00, 8'h20, 8'h5A);
    step();  // cycle 1; keep valid high with a different command, must wait for IDLE
    issue(2'b01, 8'h31, 8'h00);
    total++; if ({md_opc, md_wdi} !== {2'b11, 8'h20}) begin bad++; $display("FAIL b2b_addr1 got=%b/%h exp=11/20", md_opc, md_wdi); end
    step();  // cycle 2
    total++; if ({md_opc, md_wdi} !== {2'b01, 8'h5A}) begin bad++; $display("FAIL b2b_data1 got=%b/%h exp=01/5a", md_opc, md_wdi); end
    step();  // cycle 3
    total++; if ({rsp_valid, rsp_err, cmd_ready} !== 3'b100) begin bad++; $display("FAIL b2b_rsp1 got=%b/%b/%b exp=1/0/0", rsp_valid, rsp_err, cmd_ready); end
    step();  // cycle 4: IDLE, accepts
    total++; if ({cmd_ready, md_opc} !== 3'b100) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=1/00", cmd_ready, md_opc); end
    step(); cmd_valid = 1'b0;  // cycle 5
    total++; if ({md_opc, md_wdi} !== {2'b11, 8'h31}) begin bad++; $display("FAIL b2b_addr2 got=%b/%h exp=11/31", md_opc, md_wdi); end
    repeat (4) step();  // cycle 9
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h99}) begin bad++; $display("FAIL b2b_rsp2 got=%b/%b/%h exp=1/0/99", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_apply_lock();
    test_lock_loss();
    test_timeout();
    test_reserved();
    test_reset_abort();
    test_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pll_md_ctrl.md
# pll_md_ctrl

Sequencer for the PLL dynamic-reconfiguration (MD) port and PLL reset/lock handshake. It accepts single-register read/write commands and "apply" commands from the command handler and serializes them onto the PLL's MD bus (opcode/write-data/read-data). It drives the PLL reset, then waits for lock with a timeout. It sits between the system command layer and the PLL wrapper in the same clock domain as the MD clock.

## Interface
Parameters:
- RD_LAT, 2: cycles from READ opcode to valid md_rdo (1..15)
- RST_CYCLES, 16: pll_rst high time in clk cycles (1..255)
- LOCK_TIMEOUT, 65535: max clk cycles to wait for lock after reset release (16-bit counter)

Ports:
- clk  in  1  MD clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 write, 01 read, 10 apply, 11 reserved
- cmd_addr  in  8  MD register address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data; held until next rsp_valid
- rsp_err  out  1  error flag, qualified by rsp_valid
- md_opc  out  2  00 NOP, 01 WRITE, 10 READ, 11 ADDR
- md_ainc  out  1  address auto-increment; constant 0
- md_wdi  out  8  MD write bus (address or data)
- md_rdo  in  8  MD read bus
- pll_rst  out  1  PLL reset, active high
- pll_lock  in  1  raw PLL lock, asynchronous
- locked  out  1  synchronized lock, qualified

## Operation
- pll_lock passes through a 2-flop synchronizer (lock_s); locked = lock_s AND state not in {RST, LOCK_WAIT}.
- States: IDLE, ADDR, WR, RD, RD_WAIT, RST, LOCK_WAIT, RESP.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch op/addr/wdata. Op 00/01 -> ADDR; 10 -> RST; 11 -> RESP with err=1 (no MD activity).
- ADDR: md_opc=11, md_wdi=addr; next WR (write) or RD (read).
- WR: md_opc=01, md_wdi=wdata; -> RESP, err=0.
- RD: md_opc=10, md_wdi=0; -> RD_WAIT, counter loaded RD_LAT-1.
- RD_WAIT: md_opc=00; when counter=0 capture md_rdo into rsp_rdata, -> RESP, err=0.
- RST: pll_rst=1 for exactly RST_CYCLES cycles, -> LOCK_WAIT with 16-bit counter cleared.
- LOCK_WAIT: pll_rst=0; if lock_s=1 -> RESP err=0; else if counter=LOCK_TIMEOUT -> RESP err=1; else counter+1. Lock present on entry still requires one LOCK_WAIT cycle.
- RESP: rsp_valid=1 for one cycle, -> IDLE.
- md_opc=00 and md_wdi=0 in every state not listed above; md_ainc always 0.
- cmd inputs ignored while cmd_ready=0; no queuing.

## Timing
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, md_opc=00, md_ainc=0, md_wdi=0, pll_rst=0, locked=0, synchronizer flops 0.
- All outputs registered except cmd_ready (decode of state) and locked (lock_s AND state decode).
- Accept at edge 0: write -> ADDR cycle 1, WR cycle 2, rsp_valid cycle 3 (latency 3).
- Read -> ADDR cycle 1, READ cycle 2, md_rdo sampled at end of cycle 2+RD_LAT, rsp_valid cycle 3+RD_LAT.
- Apply -> pll_rst high cycles 1..RST_CYCLES; rsp_valid no earlier than RST_CYCLES+2 after accept.
- Lock loss in IDLE: locked drops 2 cycles after pll_lock falls; no automatic reapply.
- rst_n asserted mid-operation: immediate return to reset values, pll_rst released, no rsp_valid generated.
- Back-to-back: next command accepted the cycle after rsp_valid.

## Test plan
- Write addr 0x12 data 0xA5 -> md_opc 11/0x12 cycle 1, 01/0xA5 cycle 2, rsp_valid err=0 cycle 3.
- Read addr 0x07, RD_LAT=2, md_rdo=0x3C at sample cycle -> rsp_rdata=0x3C, rsp_valid cycle 5, err=0.
- Apply with pll_lock rising 10 cycles after reset release -> pll_rst high exactly 16 cycles, locked=0 throughout, rsp_valid err=0, locked=1 after.
- Apply with pll_lock stuck 0, LOCK_TIMEOUT=100 -> rsp_valid err=1 after 101 LOCK_WAIT cycles, locked=0.
- cmd_op=11 -> rsp_valid err=1 at cycle 1, md_opc stays 00, pll_rst stays 0.
- rst_n pulsed low during RST state -> pll_rst=0 and cmd_ready=1 immediately, no rsp_valid; next write completes normally.
